// File: rtl/mmcm_servo_pkg.sv
// Shared types and default constants for the MMCM phase-servo blocks.
// Used by mmcm_ps_sequencer and its ps_interval_timer helper.
package mmcm_servo_pkg;

   localparam int DEFAULT_BIT_DEPTH    = 32;
   localparam int DEFAULT_DONE_TIMEOUT = 64;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      COUNT     = 2'd1,
      ISSUE     = 2'd2,
      WAIT_DONE = 2'd3
   } ps_seq_state_t;

endpackage

// File: rtl/ps_interval_timer.sv
// Loadable down-counter with a zero flag.
// Holds at zero; a load takes priority over a decrement.
module ps_interval_timer #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         dec,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - W'(1);
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/mmcm_ps_sequencer.sv
// Turns the servo step interval/direction into MMCM psen/psincdec/psdone handshakes.
// Optional psdone watchdog enabled by defining MMCM_PS_TIMEOUT_EN.
module mmcm_ps_sequencer
   import mmcm_servo_pkg::*;
#(
   parameter int BIT_DEPTH    = DEFAULT_BIT_DEPTH,
   parameter int DONE_TIMEOUT = DEFAULT_DONE_TIMEOUT
) (
   input  logic                        psclk,
   input  logic                        reset,
   input  logic                        enable,
   input  logic [BIT_DEPTH-1:0]        interval,
   input  logic                        incdec,
   input  logic                        psdone,
   output logic                        psen,
   output logic                        psincdec,
   output logic                        busy,
   output logic signed [BIT_DEPTH-1:0] net_steps,
   output logic                        stray_done,
   output logic                        timeout_err
);

   localparam logic signed [BIT_DEPTH-1:0] NET_MAX = {1'b0, {(BIT_DEPTH-1){1'b1}}};
   localparam logic signed [BIT_DEPTH-1:0] NET_MIN = {1'b1, {(BIT_DEPTH-1){1'b0}}};
   localparam logic signed [BIT_DEPTH-1:0] NET_ONE = {{(BIT_DEPTH-1){1'b0}}, 1'b1};

   ps_seq_state_t state, state_nxt;

   logic cnt_load;
   logic cnt_dec;
   logic cnt_zero;
   logic latch_dir;
   logic step_done;
   logic stray;

   function automatic logic signed [BIT_DEPTH-1:0] sat_step(
      input logic signed [BIT_DEPTH-1:0] cur,
      input logic                        up
   );
      if (up) begin
         return (cur == NET_MAX) ? cur : cur + NET_ONE;
      end
      return (cur == NET_MIN) ? cur : cur - NET_ONE;
   endfunction

   ps_interval_timer #(
      .W (BIT_DEPTH)
   ) u_cnt (
      .clk      (psclk),
      .reset    (reset),
      .load     (cnt_load),
      .dec      (cnt_dec),
      .load_val (interval),
      .zero     (cnt_zero)
   );

`ifdef MMCM_PS_TIMEOUT_EN
   localparam int WD_W = $clog2(DONE_TIMEOUT) + 1;

   logic wd_load;
   logic wd_dec;
   logic wd_zero;
   logic wd_expired;

   // Loaded with DONE_TIMEOUT-1 so WAIT_DONE lasts at most DONE_TIMEOUT cycles.
   ps_interval_timer #(
      .W (WD_W)
   ) u_watchdog (
      .clk      (psclk),
      .reset    (reset),
      .load     (wd_load),
      .dec      (wd_dec),
      .load_val (WD_W'(DONE_TIMEOUT - 1)),
      .zero     (wd_zero)
   );
`endif

   always_ff @(posedge psclk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_load  = 1'b0;
      cnt_dec   = 1'b0;
      latch_dir = 1'b0;
      step_done = 1'b0;
      stray     = 1'b0;
`ifdef MMCM_PS_TIMEOUT_EN
      wd_load    = 1'b0;
      wd_dec     = 1'b0;
      wd_expired = 1'b0;
`endif
      unique case (state)
         IDLE: begin
            if (enable) begin
               state_nxt = COUNT;
               cnt_load  = 1'b1;
            end
         end
         COUNT: begin
            stray = psdone;
            if (!enable) begin
               state_nxt = IDLE;
            end else if (cnt_zero) begin
               state_nxt = ISSUE;
               latch_dir = 1'b1;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         ISSUE: begin
            stray     = psdone;
            state_nxt = WAIT_DONE;
`ifdef MMCM_PS_TIMEOUT_EN
            wd_load = 1'b1;
`endif
         end
         WAIT_DONE: begin
            // The handshake always completes; enable only picks the next state.
            if (psdone) begin
               step_done = 1'b1;
               state_nxt = enable ? COUNT : IDLE;
               cnt_load  = enable;
            end
`ifdef MMCM_PS_TIMEOUT_EN
            else if (wd_zero) begin
               wd_expired = 1'b1;
               state_nxt  = enable ? COUNT : IDLE;
               cnt_load   = enable;
            end else begin
               wd_dec = 1'b1;
            end
`endif
         end
         default: state_nxt = IDLE;
      endcase
   end

   // psen follows the ISSUE state by one register stage.
   always_ff @(posedge psclk) begin
      if (reset) begin
         psen       <= 1'b0;
         psincdec   <= 1'b0;
         busy       <= 1'b0;
         net_steps  <= '0;
         stray_done <= 1'b0;
      end else begin
         psen <= (state == ISSUE);
         busy <= (state_nxt == ISSUE) || (state_nxt == WAIT_DONE);
         if (latch_dir) begin
            psincdec <= incdec;
         end
         if (step_done) begin
            net_steps <= sat_step(net_steps, psincdec);
         end
         if (stray) begin
            stray_done <= 1'b1;
         end
      end
   end

`ifdef MMCM_PS_TIMEOUT_EN
   always_ff @(posedge psclk) begin
      if (reset) begin
         timeout_err <= 1'b0;
      end else if (wd_expired) begin
         timeout_err <= 1'b1;
      end
   end
`else
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mmcm_ps_sequencer.sv
// Self-checking bench for mmcm_ps_sequencer: scenario table, corner sequences, random steps.
module tb_mmcm_ps_sequencer;

   localparam int BD = 6;

   logic                 psclk = 1'b0;
   logic                 reset = 1'b1;
   logic                 enable = 1'b0;
   logic [BD-1:0]        interval = '0;
   logic                 incdec = 1'b0;
   logic                 psdone = 1'b0;
   logic                 psen;
   logic                 psincdec;
   logic                 busy;
   logic signed [BD-1:0] net_steps;
   logic                 stray_done;
   logic                 timeout_err;

   int checks = 0;
   int failures = 0;

   mmcm_ps_sequencer #(
      .BIT_DEPTH    (BD),
      .DONE_TIMEOUT (64)
   ) dut (
      .psclk       (psclk),
      .reset       (reset),
      .enable      (enable),
      .interval    (interval),
      .incdec      (incdec),
      .psdone      (psdone),
      .psen        (psen),
      .psincdec    (psincdec),
      .busy        (busy),
      .net_steps   (net_steps),
      .stray_done  (stray_done),
      .timeout_err (timeout_err)
   );

   always #5 psclk = ~psclk;

   typedef struct {
      int n;
      bit dir;
      int d;
      int steps;
      int exp_first;
      int exp_spacing;
      int exp_net;
   } vec_t;

   vec_t vecs[4];

   task automatic tick();
      @(posedge psclk);
      #1;
   endtask

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      reset  = 1'b1;
      enable = 1'b0;
      psdone = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Ticks until psen is seen; n = ticks taken, -1 if the bound expired.
   task automatic wait_psen(output int n);
      n = 0;
      forever begin
         tick();
         n++;
         if (psen) break;
         if (n > 300) begin
            n = -1;
            break;
         end
      end
   endtask

   // Returns psdone d cycles after psen and presents the next step's interval/direction.
   task automatic do_done(input int d, input int n_next, input bit dir_next);
      for (int i = 0; i < d; i++) begin
         if (i == 0) incdec = 1'($urandom_range(1, 0));
         if (i == d - 1) begin
            psdone   = 1'b1;
            interval = BD'(n_next);
            incdec   = dir_next;
         end
         tick();
         if (i == 0) check("psen_width", psen, 0);
      end
      psdone   = 1'b0;
      interval = BD'($urandom_range(63, 0));
   endtask

   initial begin
      int n;
      int cnt;
      int model_net;
      int n_cur, n_nxt, d;
      bit dir_cur, dir_nxt;

      vecs[0] = '{n: 4, dir: 1'b1, d: 12, steps: 3, exp_first: 6, exp_spacing: 18, exp_net: 3};
      vecs[1] = '{n: 0, dir: 1'b0, d: 5,  steps: 3, exp_first: 2, exp_spacing: 7,  exp_net: -3};
      vecs[2] = '{n: 7, dir: 1'b1, d: 1,  steps: 2, exp_first: 9, exp_spacing: 10, exp_net: 2};
      vecs[3] = '{n: 2, dir: 1'b0, d: 3,  steps: 2, exp_first: 4, exp_spacing: 7,  exp_net: -2};

      // Reset state
      do_reset();
      check("rst_psen", psen, 0);
      check("rst_psincdec", psincdec, 0);
      check("rst_busy", busy, 0);
      check("rst_net", net_steps, 0);
      check("rst_stray", stray_done, 0);
      check("rst_timeout", timeout_err, 0);

      // psdone in IDLE is ignored silently
      psdone = 1'b1;
      tick();
      psdone = 1'b0;
      tick();
      check("idle_done_stray", stray_done, 0);
      check("idle_done_net", net_steps, 0);

      // Scenario table
      foreach (vecs[v]) begin
         do_reset();
         interval = BD'(vecs[v].n);
         incdec   = vecs[v].dir;
         enable   = 1'b1;
         tick();
         for (int s = 0; s < vecs[v].steps; s++) begin
            wait_psen(n);
            if (s == 0) check($sformatf("tab%0d_first", v), n, vecs[v].exp_first);
            else        check($sformatf("tab%0d_spacing", v), vecs[v].d + n, vecs[v].exp_spacing);
            check($sformatf("tab%0d_busy", v), busy, 1);
            check($sformatf("tab%0d_dir", v), psincdec, vecs[v].dir);
            do_done(vecs[v].d, vecs[v].n, vecs[v].dir);
         end
         check($sformatf("tab%0d_net", v), net_steps, vecs[v].exp_net);
      end

      // enable drops one cycle after psen: handshake completes, then IDLE
      do_reset();
      interval = 6'd3;
      incdec   = 1'b1;
      enable   = 1'b1;
      tick();
      wait_psen(n);
      check("drop_first", n, 5);
      tick();
      enable = 1'b0;
      tick();
      tick();
      check("drop_busy_hold", busy, 1);
      psdone = 1'b1;
      tick();
      psdone = 1'b0;
      check("drop_net", net_steps, 1);
      check("drop_busy", busy, 0);
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (psen) cnt++;
      end
      check("drop_no_psen", cnt, 0);

      // psdone while counting: sticky flag, schedule and tally untouched
      do_reset();
      interval = 6'd6;
      incdec   = 1'b1;
      enable   = 1'b1;
      tick();
      tick();
      psdone = 1'b1;
      tick();
      psdone = 1'b0;
      check("stray_flag", stray_done, 1);
      wait_psen(n);
      check("stray_sched", n + 2, 8);
      check("stray_net", net_steps, 0);
      do_done(3, 6, 1'b1);
      check("stray_net_after", net_steps, 1);
      check("stray_sticky", stray_done, 1);

      // Withheld psdone
      do_reset();
      interval = 6'd2;
      incdec   = 1'b1;
      enable   = 1'b1;
      tick();
      wait_psen(n);
`ifdef MMCM_PS_TIMEOUT_EN
      cnt = 0;
      while (!timeout_err && cnt < 200) begin
         tick();
         cnt++;
      end
      check("to_cycles", cnt, 64);
      check("to_net", net_steps, 0);
      wait_psen(n);
      check("to_next_psen", n, 4);
      check("to_sticky", timeout_err, 1);
`else
      cnt = 0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (!busy) cnt++;
      end
      check("hang_busy_low", cnt, 0);
      check("hang_timeout", timeout_err, 0);
`endif

      // Reset mid-handshake, then a late psdone
      do_reset();
      interval = 6'd1;
      incdec   = 1'b1;
      enable   = 1'b1;
      tick();
      wait_psen(n);
      do_done(2, 1, 1'b1);
      wait_psen(n);
      check("rstmid_pre_net", net_steps, 1);
      tick();
      reset  = 1'b1;
      enable = 1'b0;
      tick();
      reset = 1'b0;
      check("rstmid_psen", psen, 0);
      check("rstmid_psincdec", psincdec, 0);
      check("rstmid_busy", busy, 0);
      check("rstmid_net", net_steps, 0);
      psdone = 1'b1;
      tick();
      psdone = 1'b0;
      tick();
      check("rstmid_late_net", net_steps, 0);
      check("rstmid_late_stray", stray_done, 0);
      check("rstmid_late_busy", busy, 0);

      // Saturation at both rails
      do_reset();
      interval = 6'd0;
      incdec   = 1'b1;
      enable   = 1'b1;
      tick();
      for (int i = 0; i < 40; i++) begin
         wait_psen(n);
         do_done(1, 0, 1'b1);
      end
      check("sat_max", net_steps, 31);
      for (int i = 0; i < 70; i++) begin
         wait_psen(n);
         do_done(1, 0, 1'b0);
      end
      check("sat_min", net_steps, -32);

      // Random steps against a clamped-integer tally model
      do_reset();
      model_net = 0;
      n_cur   = $urandom_range(5, 0);
      dir_cur = 1'($urandom_range(1, 0));
      interval = BD'(n_cur);
      incdec   = dir_cur;
      enable   = 1'b1;
      tick();
      interval = BD'($urandom_range(63, 0));
      for (int s = 0; s < 40; s++) begin
         n_nxt   = $urandom_range(5, 0);
         dir_nxt = 1'($urandom_range(1, 0));
         d       = $urandom_range(6, 1);
         wait_psen(n);
         check("rnd_gap", n, n_cur + 2);
         check("rnd_dir", psincdec, dir_cur);
         do_done(d, n_nxt, dir_nxt);
         model_net = dir_cur ? model_net + 1 : model_net - 1;
         if (model_net > 31)  model_net = 31;
         if (model_net < -32) model_net = -32;
         check("rnd_net", net_steps, model_net);
         n_cur   = n_nxt;
         dir_cur = dir_nxt;
      end
      check("rnd_stray", stray_done, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
